// File: rtl/apb4_pkg.sv
// Shared types and constants for the APB4 register-bank completer (apb4_slave_regbank).
package apb4_pkg;

    typedef enum logic [1:0] {IDLE, SETUP, WAIT, DONE} apb4_state_e;

    localparam int PPROT_PRIV_BIT = 0;
    localparam int WAIT_CNT_W     = 4;

endpackage

// File: rtl/apb4_regfile.sv
// NUM_REGS x DATA_WIDTH register storage with byte-lane writes and a combinational read port.
module apb4_regfile #(
    parameter int                    NUM_REGS   = 16,
    parameter int                    DATA_WIDTH = 32,
    parameter int                    IDX_W      = 4,
    parameter logic [DATA_WIDTH-1:0] RESET_VAL  = '0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    wr_en,
    input  logic [IDX_W-1:0]        idx,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH/8-1:0] strb,
    output logic [DATA_WIDTH-1:0]   rdata
);

    localparam int NB = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0] mem [NUM_REGS];
    logic                  in_range;

    assign in_range = int'(idx) < NUM_REGS;

    // NOTE: the bank is reset word by word because every register must read RESET_VAL
    // after reset; non-blocking assignments keep all lane updates on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                mem[i] <= RESET_VAL;
            end
        end else if (wr_en && in_range) begin
            for (int b = 0; b < NB; b++) begin
                if (strb[b]) begin
                    mem[idx][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    assign rdata = in_range ? mem[idx] : '0;

endmodule

// File: rtl/apb4_slave_regbank.sv
// APB4 completer: transfer FSM, wait counter, address decode and error logic over apb4_regfile.
// Optional privileged-access check is enabled by defining APB4_PROT_CHECK_EN.
module apb4_slave_regbank
    import apb4_pkg::*;
#(
    parameter int                    ADDR_WIDTH  = 8,
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    NUM_REGS    = 16,
    parameter int                    WAIT_CYCLES = 0,
    parameter logic [DATA_WIDTH-1:0] RESET_VAL   = '0
) (
    input  logic                    PCLK,
    input  logic                    PRESETn,
    input  logic                    PSEL,
    input  logic                    PENABLE,
    input  logic                    PWRITE,
    input  logic [ADDR_WIDTH-1:0]   PADDR,
    input  logic [DATA_WIDTH-1:0]   PWDATA,
    input  logic [DATA_WIDTH/8-1:0] PSTRB,
    input  logic [2:0]              PPROT,
    output logic [DATA_WIDTH-1:0]   PRDATA,
    output logic                    PREADY,
    output logic                    PSLVERR
);

    localparam int                    NB        = DATA_WIDTH / 8;
    localparam int                    LANE_BITS = $clog2(NB);
    localparam int                    IDX_W     = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [ADDR_WIDTH-1:0] LANE_MASK = ADDR_WIDTH'(NB - 1);
    localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD = WAIT_CNT_W'(WAIT_CYCLES);
    localparam logic [WAIT_CNT_W-1:0] CNT_ONE   = WAIT_CNT_W'(1);

    apb4_state_e             state_q, state_d;
    logic [WAIT_CNT_W-1:0]   cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic                    write_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic [NB-1:0]           strb_q;
    logic                    pready_q;
    logic                    accept;
    logic                    err;
    logic [ADDR_WIDTH-1:0]   idx_full;
    logic [DATA_WIDTH-1:0]   rdata;

`ifdef APB4_PROT_CHECK_EN
    logic priv_q;
`else
    logic unused_prot;
    assign unused_prot = ^PPROT;
`endif

    // A new setup phase is taken from IDLE, or straight out of DONE for back-to-back transfers.
    assign accept   = PSEL && !PENABLE && (state_q == IDLE || state_q == DONE);
    assign idx_full = addr_q >> LANE_BITS;

    always_comb begin
        err = (int'(idx_full) >= NUM_REGS)
           || ((addr_q & LANE_MASK) != '0)
           || (!write_q && (strb_q != '0));
`ifdef APB4_PROT_CHECK_EN
        err = err || !priv_q;
`endif
    end

    // State names the current access-phase cycle: SETUP is the first one, DONE the one with PREADY.
    // NOTE: every output of this block gets a default first so no path infers a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (accept) begin
                    state_d = (WAIT_LOAD == '0) ? DONE : SETUP;
                    cnt_d   = WAIT_LOAD;
                end
            end
            SETUP, WAIT: begin
                if (!PSEL) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_ONE) begin
                    state_d = DONE;
                    cnt_d   = '0;
                end else begin
                    state_d = WAIT;
                    cnt_d   = cnt_q - CNT_ONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            pready_q <= 1'b0;
            addr_q   <= '0;
            write_q  <= 1'b0;
            wdata_q  <= '0;
            strb_q   <= '0;
`ifdef APB4_PROT_CHECK_EN
            priv_q   <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            pready_q <= (state_d == DONE);
            if (accept) begin
                addr_q  <= PADDR;
                write_q <= PWRITE;
                wdata_q <= PWDATA;
                strb_q  <= PSTRB;
`ifdef APB4_PROT_CHECK_EN
                priv_q  <= PPROT[PPROT_PRIV_BIT];
`endif
            end
        end
    end

    apb4_regfile #(
        .NUM_REGS   (NUM_REGS),
        .DATA_WIDTH (DATA_WIDTH),
        .IDX_W      (IDX_W),
        .RESET_VAL  (RESET_VAL)
    ) u_regfile (
        .clk   (PCLK),
        .rst_n (PRESETn),
        .wr_en (state_q == DONE && write_q && !err),
        .idx   (idx_full[IDX_W-1:0]),
        .wdata (wdata_q),
        .strb  (strb_q),
        .rdata (rdata)
    );

    assign PREADY  = pready_q;
    assign PSLVERR = pready_q && err;
    assign PRDATA  = (pready_q && !err && !write_q) ? rdata : '0;

endmodule

// File: tb/tb_apb4_slave_regbank.sv
// Self-checking bench for apb4_slave_regbank: a zero-wait and a three-wait instance against a register-array model.
module tb_apb4_slave_regbank;

    localparam logic [31:0] RST3 = 32'h1234_5678;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  psel;
    logic        penable, pwrite;
    logic [7:0]  paddr;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    logic [2:0]  pprot;
    logic [1:0]  pready, pslverr;
    logic [31:0] prdata0, prdata3;

    logic [31:0] mdl [2][16];
    int          n_cmp = 0;
    int          n_bad = 0;

    always #5 clk = ~clk;

    apb4_slave_regbank #(.WAIT_CYCLES(0)) dut0 (
        .PCLK(clk), .PRESETn(rst_n), .PSEL(psel[0]), .PENABLE(penable), .PWRITE(pwrite),
        .PADDR(paddr), .PWDATA(pwdata), .PSTRB(pstrb), .PPROT(pprot),
        .PRDATA(prdata0), .PREADY(pready[0]), .PSLVERR(pslverr[0])
    );

    apb4_slave_regbank #(.WAIT_CYCLES(3), .RESET_VAL(RST3)) dut3 (
        .PCLK(clk), .PRESETn(rst_n), .PSEL(psel[1]), .PENABLE(penable), .PWRITE(pwrite),
        .PADDR(paddr), .PWDATA(pwdata), .PSTRB(pstrb), .PPROT(pprot),
        .PRDATA(prdata3), .PREADY(pready[1]), .PSLVERR(pslverr[1])
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] prdata_of(input int d);
        return (d == 0) ? prdata0 : prdata3;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) begin
            mdl[0][i] = 32'h0;
            mdl[1][i] = RST3;
        end
    endtask

    // One full APB transfer on instance d, checked against the model's rules.
    task automatic run(input int d, input logic wr, input logic [7:0] a, input logic [31:0] wd,
                       input logic [3:0] st, input logic [2:0] pr, input string tag,
                       output logic [31:0] rd);
        int          idx;
        int          lat;
        logic        exp_err;
        logic        obs_err;
        logic [31:0] exp_rd;
        idx     = int'(a) / 4;
        exp_err = (a % 4 != 0) || (idx >= 16) || (!wr && st != 4'h0);
`ifdef APB4_PROT_CHECK_EN
        exp_err = exp_err || !pr[0];
`endif
        exp_rd  = (!wr && !exp_err) ? mdl[d][idx] : 32'h0;

        @(posedge clk); #1;
        psel[d] = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = wd; pstrb = st; pprot = pr;
        @(posedge clk); #1;
        penable = 1'b1;
        lat = 0; rd = 32'h0; obs_err = 1'b0;
        for (int i = 1; i <= 20 && lat == 0; i++) begin
            @(negedge clk);
            if (pready[d]) begin
                lat = i; rd = prdata_of(d); obs_err = pslverr[d];
            end else begin
                check({tag, " quiet_err"}, 32'(pslverr[d]), 32'h0);
                check({tag, " quiet_rd"}, prdata_of(d), 32'h0);
            end
            @(posedge clk); #1;
        end
        psel = 2'b00; penable = 1'b0;
        check({tag, " latency"}, 32'(lat), (d == 0) ? 32'd1 : 32'd4);
        check({tag, " pslverr"}, 32'(obs_err), 32'(exp_err));
        check({tag, " prdata"}, rd, exp_rd);
        @(negedge clk);
        check({tag, " one_cycle"}, 32'(pready[d]), 32'h0);

        if (wr && !exp_err) begin
            for (int b = 0; b < 4; b++) begin
                if (st[b]) mdl[d][idx][8*b +: 8] = wd[8*b +: 8];
            end
        end
    endtask

    initial begin
        logic [31:0] rd;
        int          rd_d;
        logic        rwr;
        logic [7:0]  raddr;
        logic [3:0]  rstrb;
        logic [2:0]  rprot;

        rst_n = 1'b0; psel = 2'b00; penable = 1'b0; pwrite = 1'b0;
        paddr = 8'h0; pwdata = 32'h0; pstrb = 4'h0; pprot = 3'b001;
        model_reset();
        repeat (3) @(negedge clk);
        check("reset pready", 32'(pready), 32'h0);
        check("reset pslverr", 32'(pslverr), 32'h0);
        check("reset prdata0", prdata0, 32'h0);
        check("reset prdata3", prdata3, 32'h0);
        #2 rst_n = 1'b1;

        // Zero-wait write/read round trip
        run(0, 1'b1, 8'h04, 32'hDEAD_BEEF, 4'hF, 3'b001, "t1_wr", rd);
        run(0, 1'b0, 8'h04, 32'h0, 4'h0, 3'b001, "t1_rd", rd);
        check("t1 const", rd, 32'hDEAD_BEEF);

        // Partial-strobe write
        run(0, 1'b1, 8'h08, 32'hDEAD_BEEF, 4'hF, 3'b001, "t2_wr_full", rd);
        run(0, 1'b1, 8'h08, 32'h1122_3344, 4'h3, 3'b001, "t2_wr_lo", rd);
        run(0, 1'b0, 8'h08, 32'h0, 4'h0, 3'b001, "t2_rd", rd);
        check("t2 const", rd, 32'hDEAD_3344);
        run(0, 1'b1, 8'h08, 32'hFFFF_FFFF, 4'h0, 3'b001, "t2_wr_nostrb", rd);
        run(0, 1'b0, 8'h08, 32'h0, 4'h0, 3'b001, "t2_rd_after_noop", rd);
        check("t2 noop const", rd, 32'hDEAD_3344);

        // Error responses leave the bank untouched
        run(0, 1'b1, 8'h40, 32'h0BAD_0BAD, 4'hF, 3'b001, "t3_wr_oor", rd);
        run(0, 1'b0, 8'h05, 32'h0, 4'h0, 3'b001, "t3_rd_misal", rd);
        run(0, 1'b1, 8'h06, 32'h0BAD_0BAD, 4'hF, 3'b001, "t3_wr_misal", rd);
        run(0, 1'b0, 8'h04, 32'h0, 4'h2, 3'b001, "t3_rd_strb", rd);
        run(0, 1'b0, 8'h04, 32'h0, 4'h0, 3'b001, "t3_rd_04", rd);
        check("t3 const 04", rd, 32'hDEAD_BEEF);
        run(0, 1'b0, 8'h3C, 32'h0, 4'h0, 3'b001, "t3_rd_last", rd);

        // Three wait states, then an aborted write
        run(1, 1'b1, 8'h0C, 32'h55AA_55AA, 4'hF, 3'b001, "t4_wr", rd);
        @(posedge clk); #1;
        psel[1] = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h0C; pwdata = 32'hFFFF_FFFF; pstrb = 4'hF;
        @(posedge clk); #1;
        penable = 1'b1;
        @(negedge clk);
        check("t4 abort c1", 32'(pready[1]), 32'h0);
        @(posedge clk); #1;
        psel = 2'b00; penable = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("t4 abort quiet", 32'(pready[1]), 32'h0);
        end
        run(1, 1'b0, 8'h0C, 32'h0, 4'h0, 3'b001, "t4_rd", rd);
        check("t4 const", rd, 32'h55AA_55AA);

        // Reset in the middle of a wait state
        run(1, 1'b1, 8'h08, 32'hCAFE_F00D, 4'hF, 3'b001, "t5_wr", rd);
        run(1, 1'b0, 8'h08, 32'h0, 4'h0, 3'b001, "t5_rd_pre", rd);
        @(posedge clk); #1;
        psel[1] = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h08; pwdata = 32'h0000_0001; pstrb = 4'hF;
        @(posedge clk); #1;
        penable = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("t5 pready_in_reset", 32'(pready[1]), 32'h0);
        check("t5 prdata_in_reset", prdata3, 32'h0);
        @(negedge clk); #2;
        psel = 2'b00; penable = 1'b0; rst_n = 1'b1;
        model_reset();
        run(1, 1'b0, 8'h08, 32'h0, 4'h0, 3'b001, "t5_rd_post", rd);
        check("t5 const", rd, RST3);
        run(0, 1'b0, 8'h04, 32'h0, 4'h0, 3'b001, "t5_rd_dut0", rd);

        // PPROT privilege handling (model follows the build configuration)
        run(0, 1'b1, 8'h10, 32'h0BAD_F00D, 4'hF, 3'b000, "t6_wr_unpriv", rd);
        run(0, 1'b1, 8'h14, 32'h600D_F00D, 4'hF, 3'b001, "t6_wr_priv", rd);
        run(0, 1'b0, 8'h10, 32'h0, 4'h0, 3'b001, "t6_rd_10", rd);
        run(0, 1'b0, 8'h14, 32'h0, 4'h0, 3'b001, "t6_rd_14", rd);
        check("t6 const 14", rd, 32'h600D_F00D);
        run(0, 1'b0, 8'h14, 32'h0, 4'h0, 3'b000, "t6_rd_unpriv", rd);

        // Randomised traffic on both instances
        for (int i = 0; i < 60; i++) begin
            rd_d  = int'($urandom_range(0, 1));
            rwr   = 1'($urandom_range(0, 1));
            raddr = 8'($urandom_range(0, 71));
            if ($urandom_range(0, 3) != 0) raddr = raddr & 8'hFC;
            rstrb = 4'($urandom);
            if (!rwr && $urandom_range(0, 3) != 0) rstrb = 4'h0;
            rprot = 3'($urandom);
            if ($urandom_range(0, 3) != 0) rprot[0] = 1'b1;
            run(rd_d, rwr, raddr, $urandom, rstrb, rprot, $sformatf("rnd%0d", i), rd);
        end

        for (int r = 0; r < 16; r++) begin
            run(0, 1'b0, 8'(4 * r), 32'h0, 4'h0, 3'b001, $sformatf("sweep0_%0d", r), rd);
            run(1, 1'b0, 8'(4 * r), 32'h0, 4'h0, 3'b001, $sformatf("sweep3_%0d", r), rd);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
